msrv32_machine_control: RTL and testbench

MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

---
 rtl/msrv32_machine_control.sv | 205 ++++++++++++++++++++
 tb/tb_msrv32_machine_control.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_machine_control.sv
// ============================================================================
// Module   : msrv32_machine_control
// Purpose  : Machine-mode trap/return/WFI sequencer for the msrv32 core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_machine_control (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       stall_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       i_or_e_out,
    output logic       instret_inc_out,
    output logic [3:0] cause_out
);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3,
        ST_WFI_WAIT    = 3'd4
    } state_t;

    localparam logic [1:0] c_PC_RESET = 2'b00;
    localparam logic [1:0] c_PC_EPC   = 2'b01;
    localparam logic [1:0] c_PC_NEXT  = 2'b10;
    localparam logic [1:0] c_PC_TRAP  = 2'b11;

    localparam logic [3:0] c_CAUSE_M_EXT_INT   = 4'd11;
    localparam logic [3:0] c_CAUSE_M_SW_INT    = 4'd3;
    localparam logic [3:0] c_CAUSE_M_TIMER_INT = 4'd7;
    localparam logic [3:0] c_CAUSE_INSTR_MIS   = 4'd0;
    localparam logic [3:0] c_CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] c_CAUSE_BREAKPOINT  = 4'd3;
    localparam logic [3:0] c_CAUSE_ECALL_M     = 4'd11;
    localparam logic [3:0] c_CAUSE_LOAD_MIS    = 4'd4;
    localparam logic [3:0] c_CAUSE_STORE_MIS   = 4'd6;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_pc_src;
    logic       r_flush;
    logic       r_stall;
    logic       r_trap_taken;
    logic       r_set_epc;
    logic       r_set_cause;
    logic       r_mie_clear;
    logic       r_mie_set;
    logic       r_i_or_e;
    logic [3:0] r_cause;

    logic       w_system;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_wfi;
    logic       w_ext_irq;
    logic       w_sw_irq;
    logic       w_tmr_irq;
    logic       w_wake;
    logic       w_int_pending;
    logic       w_exception;
    logic       w_trap;
    logic [3:0] w_cause;

    // Nonzero rs1/rd leaves these as plain SYSTEM ops; decode flags illegal.
    assign w_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
    assign w_ebreak = w_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
    assign w_mret   = w_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);
    assign w_wfi    = w_system && (funct7_in == 7'b0001000) && (rs2_addr_in == 5'b00101);

    assign w_ext_irq     = meie_in & meip_in;
    assign w_sw_irq      = msie_in & msip_in;
    assign w_tmr_irq     = mtie_in & mtip_in;
    assign w_wake        = w_ext_irq | w_sw_irq | w_tmr_irq;
    assign w_int_pending = mie_in & w_wake;
    assign w_exception   = misaligned_instr_in | illegal_instr_in | w_ebreak | w_ecall |
                           misaligned_load_in | misaligned_store_in;
    assign w_trap        = w_int_pending | w_exception;

    always_comb begin
        w_cause = c_CAUSE_STORE_MIS;
        if (w_int_pending) begin
            if (w_ext_irq)             w_cause = c_CAUSE_M_EXT_INT;
            else if (w_sw_irq)         w_cause = c_CAUSE_M_SW_INT;
            else                       w_cause = c_CAUSE_M_TIMER_INT;
        end else if (misaligned_instr_in) w_cause = c_CAUSE_INSTR_MIS;
        else if (illegal_instr_in)        w_cause = c_CAUSE_ILLEGAL;
        else if (w_ebreak)                w_cause = c_CAUSE_BREAKPOINT;
        else if (w_ecall)                 w_cause = c_CAUSE_ECALL_M;
        else if (misaligned_load_in)      w_cause = c_CAUSE_LOAD_MIS;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET:       w_next_state = ST_OPERATING;
            ST_OPERATING: begin
                if (w_trap)      w_next_state = ST_TRAP_TAKEN;
                else if (w_mret) w_next_state = ST_TRAP_RETURN;
                else if (w_wfi)  w_next_state = ST_WFI_WAIT;
            end
            ST_TRAP_TAKEN:  w_next_state = ST_OPERATING;
            ST_TRAP_RETURN: w_next_state = ST_OPERATING;
            ST_WFI_WAIT: begin
                if (w_wake) w_next_state = ST_OPERATING;
            end
            default:        w_next_state = ST_RESET;
        endcase
    end

    // Outputs are registered from the next state so they equal a Moore decode of r_state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_RESET;
            r_pc_src     <= c_PC_RESET;
            r_flush      <= 1'b1;
            r_stall      <= 1'b0;
            r_trap_taken <= 1'b0;
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_i_or_e     <= 1'b0;
            r_cause      <= 4'd0;
        end else begin
            r_state      <= w_next_state;
            r_pc_src     <= c_PC_NEXT;
            r_flush      <= 1'b0;
            r_stall      <= 1'b0;
            r_trap_taken <= 1'b0;
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            case (w_next_state)
                ST_RESET: begin
                    r_pc_src <= c_PC_RESET;
                    r_flush  <= 1'b1;
                end
                ST_TRAP_TAKEN: begin
                    r_pc_src     <= c_PC_TRAP;
                    r_flush      <= 1'b1;
                    r_trap_taken <= 1'b1;
                    r_set_epc    <= 1'b1;
                    r_set_cause  <= 1'b1;
                    r_mie_clear  <= 1'b1;
                end
                ST_TRAP_RETURN: begin
                    r_pc_src  <= c_PC_EPC;
                    r_flush   <= 1'b1;
                    r_mie_set <= 1'b1;
                end
                ST_WFI_WAIT: r_stall <= 1'b1;
                default: ;
            endcase
            if (w_next_state == ST_TRAP_TAKEN) begin
                r_cause  <= w_cause;
                r_i_or_e <= w_int_pending;
            end
        end
    end

    assign pc_src_out      = r_pc_src;
    assign flush_out       = r_flush;
    assign stall_out       = r_stall;
    assign trap_taken_out  = r_trap_taken;
    assign set_epc_out     = r_set_epc;
    assign set_cause_out   = r_set_cause;
    assign mie_clear_out   = r_mie_clear;
    assign mie_set_out     = r_mie_set;
    assign i_or_e_out      = r_i_or_e;
    assign cause_out       = r_cause;
    assign instret_inc_out = (r_state == ST_OPERATING) && !w_trap && !w_mret && !w_wfi;

endmodule

`default_nettype wire

// File: tb/tb_msrv32_machine_control.sv
// ============================================================================
// Module   : tb_msrv32_machine_control
// Purpose  : Directed self-checking bench for msrv32_machine_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msrv32_machine_control;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic [1:0] pc_src_out;
    logic       flush_out, stall_out, trap_taken_out, set_epc_out, set_cause_out;
    logic       mie_clear_out, mie_set_out, i_or_e_out, instret_inc_out;
    logic [3:0] cause_out;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_MRET   = 32'h3020_0073;
    localparam logic [31:0] c_WFI    = 32'h1050_0073;
    localparam logic [31:0] c_MRET_RD1 = 32'h3020_00F3;

    msrv32_machine_control dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
        .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
        .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
        .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
        .pc_src_out(pc_src_out), .flush_out(flush_out), .stall_out(stall_out),
        .trap_taken_out(trap_taken_out), .set_epc_out(set_epc_out), .set_cause_out(set_cause_out),
        .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out), .i_or_e_out(i_or_e_out),
        .instret_inc_out(instret_inc_out), .cause_out(cause_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic set_instr(input logic [31:0] ins);
        opcode_6_to_2_in = ins[6:2];
        funct3_in        = ins[14:12];
        funct7_in        = ins[31:25];
        rs1_addr_in      = ins[19:15];
        rs2_addr_in      = ins[24:20];
        rd_addr_in       = ins[11:7];
    endtask

    task automatic clear_inputs();
        illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0; misaligned_instr_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; meip_in = 0; mtip_in = 0; msip_in = 0;
        set_instr(c_NOP);
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        clear_inputs();
        tick();
        checks++; if (pc_src_out !== 2'b00) begin errors++; $display("FAIL reset_pc_src: got %b expected 00", pc_src_out); end
        checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b expected 1", flush_out); end
        checks++; if ({stall_out, trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out, i_or_e_out, instret_inc_out} !== 8'd0)
            begin errors++; $display("FAIL reset_others: got %b expected 00000000",
                {stall_out, trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out, i_or_e_out, instret_inc_out}); end
        checks++; if (cause_out !== 4'd0) begin errors++; $display("FAIL reset_cause: got %h expected 0", cause_out); end
        rst_n_in = 1'b1;
        #1;
        checks++; if (pc_src_out !== 2'b00 || flush_out !== 1'b1) begin errors++; $display("FAIL reset_hold_cycle: got pc_src=%b flush=%b expected 00/1", pc_src_out, flush_out); end
        tick();
        checks++; if (pc_src_out !== 2'b10 || flush_out !== 1'b0 || instret_inc_out !== 1'b1)
            begin errors++; $display("FAIL reset_to_operating: got pc_src=%b flush=%b instret=%b expected 10/0/1", pc_src_out, flush_out, instret_inc_out); end
    endtask

    task automatic test_illegal();
        illegal_instr_in = 1'b1;
        #1;
        checks++; if (instret_inc_out !== 1'b0) begin errors++; $display("FAIL illegal_instret: got %b expected 0", instret_inc_out); end
        tick();
        illegal_instr_in = 1'b0;
        checks++; if (trap_taken_out !== 1'b1 || pc_src_out !== 2'b11 || flush_out !== 1'b1)
            begin errors++; $display("FAIL illegal_trap: got trap=%b pc_src=%b flush=%b expected 1/11/1", trap_taken_out, pc_src_out, flush_out); end
        checks++; if (cause_out !== 4'b0010 || i_or_e_out !== 1'b0)
            begin errors++; $display("FAIL illegal_cause: got cause=%b i_or_e=%b expected 0010/0", cause_out, i_or_e_out); end
        checks++; if (mie_clear_out !== 1'b1 || set_epc_out !== 1'b1 || set_cause_out !== 1'b1 || mie_set_out !== 1'b0)
            begin errors++; $display("FAIL illegal_csr_ctl: got clr=%b epc=%b cause=%b set=%b expected 1/1/1/0", mie_clear_out, set_epc_out, set_cause_out, mie_set_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b0 || pc_src_out !== 2'b10 || cause_out !== 4'b0010)
            begin errors++; $display("FAIL illegal_return_op: got trap=%b pc_src=%b cause=%b expected 0/10/0010", trap_taken_out, pc_src_out, cause_out); end
    endtask

    task automatic test_interrupt_priority();
        // mie, meie, msie, mtie, meip, msip, mtip, load ; expected cause, i_or_e
        logic [7:0] vec [4];
        logic [4:0] exp [4];
        vec[0] = 8'b1_101_101_1; exp[0] = {4'd11, 1'b1};
        vec[1] = 8'b1_011_011_0; exp[1] = {4'd3,  1'b1};
        vec[2] = 8'b1_001_001_0; exp[2] = {4'd7,  1'b1};
        vec[3] = 8'b0_100_100_1; exp[3] = {4'd4,  1'b0};
        for (int i = 0; i < 4; i++) begin
            {mie_in, meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in, misaligned_load_in} = vec[i];
            tick();
            clear_inputs();
            checks++; if (trap_taken_out !== 1'b1 || {cause_out, i_or_e_out} !== exp[i])
                begin errors++; $display("FAIL int_prio[%0d]: got trap=%b cause=%0d i_or_e=%b expected 1/%0d/%b",
                    i, trap_taken_out, cause_out, i_or_e_out, exp[i][4:1], exp[i][0]); end
            tick();
        end
    endtask

    task automatic test_exception_priority();
        // misinstr, illegal, instr, load, store -> cause
        logic [1:0]  flg  [6];
        logic [31:0] ins  [6];
        logic [1:0]  ls   [6];
        logic [3:0]  exp  [6];
        flg[0] = 2'b11; ins[0] = c_EBREAK; ls[0] = 2'b11; exp[0] = 4'd0;
        flg[1] = 2'b01; ins[1] = c_ECALL;  ls[1] = 2'b10; exp[1] = 4'd2;
        flg[2] = 2'b00; ins[2] = c_EBREAK; ls[2] = 2'b11; exp[2] = 4'd3;
        flg[3] = 2'b00; ins[3] = c_ECALL;  ls[3] = 2'b11; exp[3] = 4'd11;
        flg[4] = 2'b00; ins[4] = c_NOP;    ls[4] = 2'b11; exp[4] = 4'd4;
        flg[5] = 2'b00; ins[5] = c_NOP;    ls[5] = 2'b01; exp[5] = 4'd6;
        for (int i = 0; i < 6; i++) begin
            {misaligned_instr_in, illegal_instr_in} = flg[i];
            {misaligned_load_in, misaligned_store_in} = ls[i];
            set_instr(ins[i]);
            tick();
            clear_inputs();
            checks++; if (trap_taken_out !== 1'b1 || cause_out !== exp[i] || i_or_e_out !== 1'b0)
                begin errors++; $display("FAIL exc_prio[%0d]: got trap=%b cause=%0d i_or_e=%b expected 1/%0d/0",
                    i, trap_taken_out, cause_out, i_or_e_out, exp[i]); end
            tick();
        end
    endtask

    task automatic test_mret();
        set_instr(c_MRET);
        #1;
        checks++; if (instret_inc_out !== 1'b0) begin errors++; $display("FAIL mret_instret: got %b expected 0", instret_inc_out); end
        tick();
        set_instr(c_NOP);
        checks++; if (pc_src_out !== 2'b01 || mie_set_out !== 1'b1 || flush_out !== 1'b1 || trap_taken_out !== 1'b0 || mie_clear_out !== 1'b0)
            begin errors++; $display("FAIL mret_return: got pc_src=%b mie_set=%b flush=%b trap=%b clr=%b expected 01/1/1/0/0",
                pc_src_out, mie_set_out, flush_out, trap_taken_out, mie_clear_out); end
        tick();
        checks++; if (pc_src_out !== 2'b10 || mie_set_out !== 1'b0 || instret_inc_out !== 1'b1)
            begin errors++; $display("FAIL mret_to_op: got pc_src=%b mie_set=%b instret=%b expected 10/0/1", pc_src_out, mie_set_out, instret_inc_out); end
        // Trap wins over MRET
        set_instr(c_MRET);
        illegal_instr_in = 1'b1;
        tick();
        clear_inputs();
        checks++; if (pc_src_out !== 2'b11 || cause_out !== 4'd2 || mie_set_out !== 1'b0)
            begin errors++; $display("FAIL mret_trap_wins: got pc_src=%b cause=%0d mie_set=%b expected 11/2/0", pc_src_out, cause_out, mie_set_out); end
        tick();
        // MRET with rd != 0 is not acted on here
        set_instr(c_MRET_RD1);
        #1;
        checks++; if (instret_inc_out !== 1'b1) begin errors++; $display("FAIL mret_bad_enc_instret: got %b expected 1", instret_inc_out); end
        tick();
        set_instr(c_NOP);
        checks++; if (pc_src_out !== 2'b10 || flush_out !== 1'b0)
            begin errors++; $display("FAIL mret_bad_enc: got pc_src=%b flush=%b expected 10/0", pc_src_out, flush_out); end
    endtask

    task automatic test_wfi();
        mtie_in = 1'b1;
        set_instr(c_WFI);
        #1;
        checks++; if (instret_inc_out !== 1'b0) begin errors++; $display("FAIL wfi_instret: got %b expected 0", instret_inc_out); end
        tick();
        set_instr(c_NOP);
        for (int i = 0; i < 5; i++) begin
            checks++; if (stall_out !== 1'b1 || pc_src_out !== 2'b10 || instret_inc_out !== 1'b0 || trap_taken_out !== 1'b0)
                begin errors++; $display("FAIL wfi_stall[%0d]: got stall=%b pc_src=%b instret=%b trap=%b expected 1/10/0/0",
                    i, stall_out, pc_src_out, instret_inc_out, trap_taken_out); end
            tick();
        end
        mtip_in = 1'b1;
        tick();
        checks++; if (stall_out !== 1'b0 || pc_src_out !== 2'b10 || trap_taken_out !== 1'b0)
            begin errors++; $display("FAIL wfi_wake: got stall=%b pc_src=%b trap=%b expected 0/10/0", stall_out, pc_src_out, trap_taken_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b0 || instret_inc_out !== 1'b1)
            begin errors++; $display("FAIL wfi_no_trap: got trap=%b instret=%b expected 0/1", trap_taken_out, instret_inc_out); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        illegal_instr_in = 1'b1;
        tick();
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b0 || pc_src_out !== 2'b10)
            begin errors++; $display("FAIL b2b_gap: got trap=%b pc_src=%b expected 0/10", trap_taken_out, pc_src_out); end
        tick();
        illegal_instr_in = 1'b0;
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", trap_taken_out); end
    endtask

    task automatic test_reset_mid_trap();
        mie_in = 1'b1; msie_in = 1'b1; msip_in = 1'b1;
        tick();
        clear_inputs();
        checks++; if (trap_taken_out !== 1'b1 || cause_out !== 4'd3)
            begin errors++; $display("FAIL midrst_pre: got trap=%b cause=%0d expected 1/3", trap_taken_out, cause_out); end
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (pc_src_out !== 2'b00 || flush_out !== 1'b1 || cause_out !== 4'd0 || i_or_e_out !== 1'b0)
            begin errors++; $display("FAIL midrst_vals: got pc_src=%b flush=%b cause=%0d i_or_e=%b expected 00/1/0/0",
                pc_src_out, flush_out, cause_out, i_or_e_out); end
        checks++; if ({trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, instret_inc_out} !== 5'd0)
            begin errors++; $display("FAIL midrst_ctl: got %b expected 00000",
                {trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, instret_inc_out}); end
        tick();
        rst_n_in = 1'b1;
        tick();
        checks++; if (pc_src_out !== 2'b10 || instret_inc_out !== 1'b1)
            begin errors++; $display("FAIL midrst_recover: got pc_src=%b instret=%b expected 10/1", pc_src_out, instret_inc_out); end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_interrupt_priority();
        test_exception_priority();
        test_mret();
        test_wfi();
        test_back_to_back();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
